// File: rtl/wb_obi_bridge_if.sv
// Bus bundles for wb_obi_bridge: a Wishbone-classic bus and an OBI bus,
// each with master/slave modports. Signal names keep the bridge's pin names.
interface wb_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [BE_W-1:0]   wbs_sel_i;
    logic [ADDR_W-1:0] wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_o;
    logic              wbs_err_o;
    logic [DATA_W-1:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );
endinterface

interface obi_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // valid/ready: the address phase (req_o + addr/we/be/wdata) is held stable
    // until the cycle gnt_i is sampled high; the response completes in the
    // cycle rvalid_i is sampled high, with err_i only meaningful in that cycle.
    logic              req_o;
    logic              gnt_i;
    logic [ADDR_W-1:0] addr_o;
    logic              we_o;
    logic [BE_W-1:0]   be_o;
    logic [DATA_W-1:0] wdata_o;
    logic              rvalid_i;
    logic [DATA_W-1:0] rdata_i;
    logic              err_i;

    modport master (
        output req_o, addr_o, we_o, be_o, wdata_o,
        input  gnt_i, rvalid_i, rdata_i, err_i
    );

    modport slave (
        input  req_o, addr_o, we_o, be_o, wdata_o,
        output gnt_i, rvalid_i, rdata_i, err_i
    );
endinterface

// File: rtl/wb_obi_bridge.sv
// Wishbone-classic slave to OBI master bridge, one OBI transfer per WB cycle.
// Define WB_OBI_TIMEOUT_EN to build the response timeout, DRAIN state and grant tracking.
module wb_obi_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic        clk_i,
    input  logic        wb_rst_i,
    wb_bus_if.slave     wb,
    obi_bus_if.master   obi,
    output logic [2:0]  dbg_state
);
    localparam int BE_W = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("wb_obi_bridge: DATA_W must be a multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_timeout
        $error("wb_obi_bridge: TIMEOUT must lie in 1..2^TO_W-1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              err_flag_q, err_flag_d;
    logic              aborted_q, aborted_d;
    logic              abort_now;
    logic              cap_req;
    logic              cap_rdata;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef WB_OBI_TIMEOUT_EN
    logic              granted_q, granted_d;
    logic [TO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              tmo_pulse_q, tmo_pulse_d;
    logic              tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TO_W'(TIMEOUT - 1));
`endif

    // Once the WB master walks away, the OBI side still finishes silently.
    assign abort_now = aborted_q | ~wb.wbs_cyc_i;

    always_comb begin
        state_d     = state_q;
        err_flag_d  = err_flag_q;
        aborted_d   = aborted_q;
        cap_req     = 1'b0;
        cap_rdata   = 1'b0;
`ifdef WB_OBI_TIMEOUT_EN
        granted_d   = granted_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_pulse_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                err_flag_d = 1'b0;
                aborted_d  = 1'b0;
`ifdef WB_OBI_TIMEOUT_EN
                granted_d  = 1'b0;
                tmo_cnt_d  = '0;
`endif
                if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                    cap_req = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!wb.wbs_cyc_i) aborted_d = 1'b1;
                if (obi.gnt_i) state_d = S_RESP;
`ifdef WB_OBI_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (obi.gnt_i) granted_d = 1'b1;
                if (tmo_hit) begin
                    state_d     = S_DRAIN;
                    tmo_pulse_d = ~abort_now;
                end
`endif
            end
            S_RESP: begin
                if (!wb.wbs_cyc_i) aborted_d = 1'b1;
`ifdef WB_OBI_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if (obi.rvalid_i) begin
                    err_flag_d = obi.err_i;
                    cap_rdata  = ~we_q & ~obi.err_i;
                    state_d    = abort_now ? S_IDLE : S_DONE;
                end
`ifdef WB_OBI_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d     = S_DRAIN;
                    tmo_pulse_d = ~abort_now;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
`ifdef WB_OBI_TIMEOUT_EN
                if (!granted_q) begin
                    if (obi.gnt_i) granted_d = 1'b1;
                end else if (obi.rvalid_i) begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            err_flag_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_flag_q <= err_flag_d;
            aborted_q  <= aborted_d;
        end
    end

`ifdef WB_OBI_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            granted_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            granted_q   <= granted_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end
`endif

    // Address phase is captured once on acceptance and frozen until the next cycle.
    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (cap_req) begin
            addr_q  <= wb.wbs_adr_i;
            we_q    <= wb.wbs_we_i;
            be_q    <= wb.wbs_sel_i;
            wdata_q <= wb.wbs_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rdata_q <= '0;
        end else if (cap_rdata) begin
            rdata_q <= obi.rdata_i;
        end
    end

    assign obi.addr_o  = addr_q;
    assign obi.we_o    = we_q;
    assign obi.be_o    = be_q;
    assign obi.wdata_o = wdata_q;
    assign wb.wbs_dat_o = rdata_q;

`ifdef WB_OBI_TIMEOUT_EN
    assign obi.req_o     = (state_q == S_REQ) | ((state_q == S_DRAIN) & ~granted_q);
    assign wb.wbs_err_o  = ((state_q == S_DONE) & err_flag_q) | tmo_pulse_q;
`else
    assign obi.req_o     = (state_q == S_REQ);
    assign wb.wbs_err_o  = (state_q == S_DONE) & err_flag_q;
`endif
    assign wb.wbs_ack_o  = (state_q == S_DONE) & ~err_flag_q;

    assign dbg_state = state_q;
endmodule

// File: tb/tb_wb_obi_bridge.sv
// Directed bench for wb_obi_bridge: read, stalled write, OBI error, abort,
// timeout (or indefinite wait without WB_OBI_TIMEOUT_EN) and async reset mid-transfer.
module tb_wb_obi_bridge;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;
    int         total = 0;
    int         bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_bus_if  #(.ADDR_W(32), .DATA_W(32)) wb ();
    obi_bus_if #(.ADDR_W(32), .DATA_W(32)) obi ();

    wb_obi_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TO_W   (8),
        .TIMEOUT(10)
    ) dut (
        .clk_i    (clk),
        .wb_rst_i (rst),
        .wb       (wb),
        .obi      (obi),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_sel_i = sel;
        wb.wbs_dat_i = dat;
    endtask

    task automatic wb_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    // One-cycle grant, then one-cycle response; leaves the bench in the DONE cycle.
    task automatic obi_fast(input logic [31:0] rdata, input logic err);
        obi.gnt_i = 1'b1;
        tick();
        obi.gnt_i    = 1'b0;
        obi.rvalid_i = 1'b1;
        obi.rdata_i  = rdata;
        obi.err_i    = err;
        tick();
        obi.rvalid_i = 1'b0;
        obi.err_i    = 1'b0;
    endtask

    task automatic check_read_ack(input string tag);
        logic [31:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_ack"}, 32'(wb.wbs_ack_o), 32'd1);
        check({tag, "_err"}, 32'(wb.wbs_err_o), 32'd0);
        check({tag, "_data"}, wb.wbs_dat_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic err_seen;
        rst = 1'b1;
        wb_idle();
        wb.wbs_sel_i = '0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        obi.gnt_i    = 1'b0;
        obi.rvalid_i = 1'b0;
        obi.rdata_i  = '0;
        obi.err_i    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req",   32'(obi.req_o), 32'd0);
        check("rst_ack",   32'(wb.wbs_ack_o), 32'd0);
        check("rst_err",   32'(wb.wbs_err_o), 32'd0);
        check("rst_dat",   wb.wbs_dat_o, 32'd0);
        check("rst_addr",  obi.addr_o, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Basic read at minimum latency
        wb_req(1'b0, 32'h3000_0010, 4'hF, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        check("rd_req_c1",  32'(obi.req_o), 32'd1);
        check("rd_addr",    obi.addr_o, 32'h3000_0010);
        check("rd_we",      32'(obi.we_o), 32'd0);
        check("rd_be",      32'(obi.be_o), 32'hF);
        obi.gnt_i = 1'b1;
        tick();
        obi.gnt_i = 1'b0;
        check("rd_state_c2", 32'(dbg_state), 32'(ST_RESP));
        check("rd_req_c2",   32'(obi.req_o), 32'd0);
        obi.rvalid_i = 1'b1;
        obi.rdata_i  = 32'hDEAD_BEEF;
        tick();
        obi.rvalid_i = 1'b0;
        check_read_ack("rd_c3");
        wb_idle();
        tick();
        check("rd_ack_drop", 32'(wb.wbs_ack_o), 32'd0);
        check("rd_idle",     32'(dbg_state), 32'(ST_IDLE));

        // Write with a 5-cycle grant stall and a 3-cycle response stall
        wb_req(1'b1, 32'h1000_0020, 4'b0101, 32'h1234_5678);
        tick();
        wb.wbs_adr_i = 32'hFFFF_0000;
        wb.wbs_dat_i = 32'h0BAD_0BAD;
        wb.wbs_sel_i = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            obi.gnt_i = (i == 5);
            check("wr_req_held", 32'(obi.req_o), 32'd1);
            check("wr_addr_frozen", obi.addr_o, 32'h1000_0020);
            check("wr_wdata_frozen", obi.wdata_o, 32'h1234_5678);
            check("wr_be_frozen", 32'(obi.be_o), 32'h5);
            check("wr_no_early_ack", 32'(wb.wbs_ack_o), 32'd0);
            tick();
        end
        obi.gnt_i = 1'b0;
        check("wr_we", 32'(obi.we_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("wr_no_ack_at_grant", 32'(wb.wbs_ack_o), 32'd0);
            check("wr_state_resp", 32'(dbg_state), 32'(ST_RESP));
            tick();
        end
        obi.rvalid_i = 1'b1;
        obi.rdata_i  = 32'hFFFF_FFFF;
        tick();
        obi.rvalid_i = 1'b0;
        check("wr_ack", 32'(wb.wbs_ack_o), 32'd1);
        check("wr_dat_kept", wb.wbs_dat_o, 32'hDEAD_BEEF);
        wb_idle();
        tick();
        check("wr_single_ack", 32'(wb.wbs_ack_o), 32'd0);

        // OBI error response
        wb_req(1'b0, 32'h3000_0040, 4'hF, 32'h0);
        tick();
        obi_fast(32'h5555_5555, 1'b1);
        check("oerr_err", 32'(wb.wbs_err_o), 32'd1);
        check("oerr_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("oerr_dat_kept", wb.wbs_dat_o, 32'hDEAD_BEEF);
        wb_idle();
        tick();
        check("oerr_single_pulse", 32'(wb.wbs_err_o), 32'd0);

        // WB abort during RESP; new read waits for the outstanding response
        wb_req(1'b0, 32'h3000_0080, 4'hF, 32'h0);
        tick();
        obi.gnt_i = 1'b1;
        tick();
        obi.gnt_i = 1'b0;
        wb_idle();
        tick();
        wb_req(1'b0, 32'h3000_0090, 4'hF, 32'h0);
        tick();
        check("abt_new_req_blocked", 32'(obi.req_o), 32'd0);
        check("abt_state_resp", 32'(dbg_state), 32'(ST_RESP));
        obi.rvalid_i = 1'b1;
        obi.rdata_i  = 32'h1111_1111;
        tick();
        obi.rvalid_i = 1'b0;
        check("abt_no_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("abt_no_err", 32'(wb.wbs_err_o), 32'd0);
        check("abt_idle", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("abt_next_req", 32'(obi.req_o), 32'd1);
        check("abt_next_addr", obi.addr_o, 32'h3000_0090);
        exp_q.push_back(32'hCAFE_F00D);
        obi_fast(32'hCAFE_F00D, 1'b0);
        check_read_ack("abt_next");
        wb_idle();
        tick();

`ifdef WB_OBI_TIMEOUT_EN
        // Timeout with TIMEOUT=10: REQ entered in cycle 1, err in cycle 11
        wb_req(1'b0, 32'h3000_00A0, 4'hF, 32'h0);
        tick();
        obi.gnt_i = 1'b1;
        err_seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            err_seen = err_seen | wb.wbs_err_o | wb.wbs_ack_o;
            tick();
            obi.gnt_i = 1'b0;
        end
        err_seen = err_seen | wb.wbs_err_o | wb.wbs_ack_o;
        check("tmo_no_early_err", 32'(err_seen), 32'd0);
        tick();
        check("tmo_err", 32'(wb.wbs_err_o), 32'd1);
        check("tmo_no_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("tmo_drain", 32'(dbg_state), 32'(ST_DRAIN));
        wb_idle();
        tick();
        check("tmo_err_pulse", 32'(wb.wbs_err_o), 32'd0);
        wb_req(1'b0, 32'h3000_00B0, 4'hF, 32'h0);
        tick();
        tick();
        check("tmo_stb_ignored", 32'(obi.req_o), 32'd0);
        check("tmo_still_drain", 32'(dbg_state), 32'(ST_DRAIN));
        obi.rvalid_i = 1'b1;
        obi.rdata_i  = 32'h7777_7777;
        tick();
        obi.rvalid_i = 1'b0;
        check("tmo_drained_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("tmo_late_discarded", wb.wbs_dat_o, 32'hCAFE_F00D);
        check("tmo_late_no_ack", 32'(wb.wbs_ack_o), 32'd0);
        tick();
        check("tmo_next_addr", obi.addr_o, 32'h3000_00B0);
        exp_q.push_back(32'h0BAD_CAFE);
        obi_fast(32'h0BAD_CAFE, 1'b0);
        check_read_ack("tmo_next");
        wb_idle();
        tick();
`else
        // Without the timeout the bridge waits indefinitely for the response
        wb_req(1'b0, 32'h3000_00A0, 4'hF, 32'h0);
        tick();
        obi.gnt_i = 1'b1;
        err_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            err_seen = err_seen | wb.wbs_err_o | wb.wbs_ack_o;
            tick();
            obi.gnt_i = 1'b0;
        end
        check("wait_no_term", 32'(err_seen), 32'd0);
        check("wait_state_resp", 32'(dbg_state), 32'(ST_RESP));
        exp_q.push_back(32'h0BAD_CAFE);
        obi.rvalid_i = 1'b1;
        obi.rdata_i  = 32'h0BAD_CAFE;
        tick();
        obi.rvalid_i = 1'b0;
        check_read_ack("wait_late");
        wb_idle();
        tick();
`endif

        // Asynchronous reset while in REQ
        wb_req(1'b1, 32'h3000_00C0, 4'b0011, 32'hA5A5_A5A5);
        tick();
        check("arst_pre_req", 32'(obi.req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req",   32'(obi.req_o), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("arst_addr",  obi.addr_o, 32'd0);
        check("arst_wdata", obi.wdata_o, 32'd0);
        check("arst_be",    32'(obi.be_o), 32'd0);
        check("arst_we",    32'(obi.we_o), 32'd0);
        check("arst_dat",   wb.wbs_dat_o, 32'd0);
        check("arst_ack",   32'(wb.wbs_ack_o), 32'd0);
        check("arst_err",   32'(wb.wbs_err_o), 32'd0);
        wb_idle();
        tick();
        rst = 1'b0;
        tick();
        check("arst_stays_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_obi_bridge.md
# wb_obi_bridge

Parametrised Wishbone-classic-slave to OBI-master bridge, the next-generation replacement for the fixed 32-bit WB→OBI adapter in the Caravel user-project wrapper. A registered FSM issues one OBI transfer per WB cycle. Reads and writes both complete on OBI `rvalid_i`, not on grant. OBI `err_i` is forwarded as WB `wbs_err_o`, and an optional timeout frees a WB master stuck on a silent OBI slave.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be a multiple of 8, giving `BE_W = DATA_W/8`.
- `TO_W`, 8, timeout counter width.
- `TIMEOUT`, 200, cycles in REQ+RESP before a timeout error; range 1..2^TO_W-1.
- `clk_i` in 1: single clock for the whole block.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_cyc_i` in 1: WB cycle.
- `wbs_stb_i` in 1: WB strobe.
- `wbs_we_i` in 1: WB write enable.
- `wbs_sel_i` in BE_W: byte selects.
- `wbs_adr_i` in ADDR_W: WB address.
- `wbs_dat_i` in DATA_W: WB write data.
- `wbs_ack_o` out 1: WB ack, one-cycle pulse.
- `wbs_err_o` out 1: WB error, one-cycle pulse; never asserted together with ack.
- `wbs_dat_o` out DATA_W: registered read data.
- `req_o` out 1: OBI request.
- `gnt_i` in 1: OBI grant.
- `addr_o` out ADDR_W: OBI address.
- `we_o` out 1: OBI write enable.
- `be_o` out BE_W: OBI byte enables.
- `wdata_o` out DATA_W: OBI write data.
- `rvalid_i` in 1: OBI response valid.
- `rdata_i` in DATA_W: OBI read data.
- `err_i` in 1: OBI response error; sampled only when `rvalid_i`=1.

## Operation
- FSM states: IDLE, REQ, RESP, DONE, DRAIN. Reset state is IDLE.
- **IDLE**: when `wbs_cyc_i & wbs_stb_i`, register adr/we/sel/dat into `addr_o`/`we_o`/`be_o`/`wdata_o`, then go to REQ.
- **REQ**: `req_o`=1; the address phase stays frozen until `gnt_i`, then go to RESP. The request is never retracted.
- **RESP**: on `rvalid_i`:
  - capture `rdata_i` into `wbs_dat_o` (reads only; writes leave it unchanged);
  - latch `err_i` into an err flag;
  - go to DONE.
- **DONE**: pulse `wbs_err_o` if the err flag is set, otherwise pulse `wbs_ack_o`. Then go to IDLE.
- **WB abort**: if `wbs_cyc_i` falls while in REQ or RESP, the OBI transfer still completes. The DONE pulse is suppressed and the FSM returns to IDLE.
- **Timeout**: a counter clears in IDLE and increments each cycle in REQ/RESP. On reaching `TIMEOUT`:
  - `wbs_err_o` pulses for one cycle;
  - the FSM goes to DRAIN.
- **DRAIN**:
  - keep `req_o` until `gnt_i` if the transfer is not yet granted (tracked by a `granted` flag);
  - then wait for `rvalid_i`, discard the response, and go to IDLE;
  - no WB request is accepted while in DRAIN.
- A `gnt_i` or `rvalid_i` arriving in IDLE or DONE is ignored. A spurious `rvalid_i` in REQ is ignored.

## Timing
- Reset values: every output is 0, including `wbs_dat_o`, `addr_o`, `be_o` and `wdata_o`.
- All outputs are registered or decoded directly from state; there is no input→output combinational path.
- Minimum latency, with `gnt_i` and `rvalid_i` each arriving in the first possible cycle:
  - stb sampled at edge 0;
  - `req_o` high in cycle 1;
  - RESP in cycle 2;
  - ack in cycle 3.
- Throughput is at most one transfer per 4 cycles. The master must drop stb, or present a new request, after the ack cycle.
- An asynchronous reset mid-transfer returns the FSM to IDLE immediately and drops `req_o` without waiting for the OBI response.

## Configuration
- `WB_OBI_TIMEOUT_EN` defined: timeout counter, DRAIN state and `granted` tracking are compiled in.
- Macro undefined:
  - none of that logic is built and `TIMEOUT`/`TO_W` are unused;
  - the bridge waits indefinitely in REQ/RESP;
  - `wbs_err_o` is driven only by `err_i`.

## Test plan
- **Basic read**: read 0x3000_0010, `gnt_i` same cycle, `rvalid_i` next cycle, rdata 0xDEAD_BEEF → `wbs_dat_o`=0xDEAD_BEEF with ack in cycle 3.
- **Write with stalls**: write 0x1234_5678, sel 4'b0101, `gnt_i` delayed 5 cycles, `rvalid_i` delayed 3 → `addr_o`/`wdata_o`/`be_o` stable while `req_o`=1; one ack after `rvalid_i`; no ack at grant.
- **OBI error**: `rvalid_i` with `err_i`=1 → `wbs_err_o` pulses once, `wbs_ack_o` stays 0, `wbs_dat_o` unchanged.
- **Abort**: drop `wbs_cyc_i` in RESP → no ack or err; next read is accepted only after `rvalid_i`.
- **Timeout** (`WB_OBI_TIMEOUT_EN`, TIMEOUT=10): no `rvalid_i` → err at cycle 10 after REQ entry; a new stb is ignored until a late `rvalid_i`, then serviced normally.
- **Reset mid-transfer**: assert `wb_rst_i` in REQ → `req_o`=0 with no clock edge; all outputs are 0.
